// File: rtl/parity_stream_checker_if.sv
// Beat stream into the parity checker and its per-beat, per-packet and counter results.
interface parity_stream_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_pb;
  logic              in_last;
  logic              clr_cnt;
  logic              err_valid;
  logic              err;
  logic              pkt_done;
  logic              pkt_err;
  logic              pkt_active;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output in_valid, in_data, in_pb, in_last, clr_cnt,
    input  err_valid, err, pkt_done, pkt_err, pkt_active, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_pb, in_last, clr_cnt,
    output err_valid, err, pkt_done, pkt_err, pkt_active, err_cnt
  );
endinterface

// File: rtl/parity_stream_checker.sv
// Per-beat parity check with packet-level error aggregation and a saturating error counter.
module parity_stream_checker #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ODD_MODE = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  parity_stream_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             acc, acc_nxt;
  logic             err_valid_q, err_valid_nxt;
  logic             err_q, err_nxt;
  logic             pkt_done_q, pkt_done_nxt;
  logic             pkt_err_q, pkt_err_nxt;
  logic             pkt_active_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             beat_err_c;

  // A set bit means the beat's parity disagrees with the configured mode.
  always_comb begin
    beat_err_c = (^bus.in_data) ^ bus.in_pb ^ 1'(ODD_MODE);
  end

  // Packet FSM and per-beat result generation.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    err_valid_nxt = bus.in_valid;
    err_nxt       = bus.in_valid & beat_err_c;
    pkt_done_nxt  = 1'b0;
    pkt_err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            pkt_done_nxt = 1'b1;
            pkt_err_nxt  = beat_err_c;
          end else begin
            state_nxt = IN_PKT;
            acc_nxt   = beat_err_c;
          end
        end
      end
      IN_PKT: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            pkt_done_nxt = 1'b1;
            pkt_err_nxt  = acc | beat_err_c;
            acc_nxt      = 1'b0;
            state_nxt    = IDLE;
          end else begin
            acc_nxt = acc | beat_err_c;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = 1'b0;
      end
    endcase
  end

  // Clear takes effect before a same-cycle increment; the count sticks at its maximum.
  always_comb begin
    cnt_nxt = bus.clr_cnt ? '0 : cnt_q;
    if (bus.in_valid && beat_err_c && (cnt_nxt != CNT_MAX)) begin
      cnt_nxt = cnt_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= 1'b0;
      err_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      pkt_active_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      err_valid_q  <= err_valid_nxt;
      err_q        <= err_nxt;
      pkt_done_q   <= pkt_done_nxt;
      pkt_err_q    <= pkt_err_nxt;
      pkt_active_q <= (state_nxt == IN_PKT);
      cnt_q        <= cnt_nxt;
    end
  end

  assign bus.err_valid  = err_valid_q;
  assign bus.err        = err_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.pkt_err    = pkt_err_q;
  assign bus.pkt_active = pkt_active_q;
  assign bus.err_cnt    = cnt_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Drives one beat stream into three checker configurations and compares each against a packet-level model.
module tb_parity_stream_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  parity_stream_checker_if #(.DATA_W(4), .CNT_W(8)) if0 ();
  parity_stream_checker_if #(.DATA_W(4), .CNT_W(8)) if1 ();
  parity_stream_checker_if #(.DATA_W(4), .CNT_W(2)) if2 ();

  parity_stream_checker #(.DATA_W(4), .ODD_MODE(0), .CNT_W(8)) dut_even (.clk(clk), .rst(rst), .bus(if0));
  parity_stream_checker #(.DATA_W(4), .ODD_MODE(1), .CNT_W(8)) dut_odd  (.clk(clk), .rst(rst), .bus(if1));
  parity_stream_checker #(.DATA_W(4), .ODD_MODE(0), .CNT_W(2)) dut_sat  (.clk(clk), .rst(rst), .bus(if2));

  int passed = 0;
  int total  = 0;

  // Model: instance configuration and expected outputs.
  int         odd_m[3] = '{0, 1, 0};
  int         cmax_m[3] = '{255, 255, 3};
  logic       e_ev[3], e_err[3], e_pd[3], e_pe[3], e_act[3];
  int         e_cnt[3];
  logic [4:0] pkt_q[$];

  function automatic logic beat_err_m(int i, logic [4:0] b);
    return 1'((($countones(b[3:0]) + int'(b[4]) + odd_m[i]) % 2));
  endfunction

  task automatic model_update(input logic r, v, input logic [3:0] d, input logic pb, last, clr);
    logic [4:0] b;
    logic       any;
    b = {pb, d};
    if (r) begin
      pkt_q.delete();
      for (int i = 0; i < 3; i++) begin
        e_ev[i] = 0; e_err[i] = 0; e_pd[i] = 0; e_pe[i] = 0; e_act[i] = 0; e_cnt[i] = 0;
      end
      return;
    end
    if (v) pkt_q.push_back(b);
    for (int i = 0; i < 3; i++) begin
      e_ev[i]  = v;
      e_err[i] = v & beat_err_m(i, b);
      if (clr) e_cnt[i] = 0;
      if (v && beat_err_m(i, b) && e_cnt[i] < cmax_m[i]) e_cnt[i] = e_cnt[i] + 1;
      e_pd[i] = v & last;
      any = 1'b0;
      if (v && last) foreach (pkt_q[k]) any = any | beat_err_m(i, pkt_q[k]);
      e_pe[i] = any;
    end
    if (v && last) pkt_q.delete();
    for (int i = 0; i < 3; i++) e_act[i] = (pkt_q.size() > 0);
  endtask

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
  endtask

  task automatic get_obs(input int i, output logic [4:0] f, output logic [31:0] c);
    case (i)
      0: begin f = {if0.err_valid, if0.err, if0.pkt_done, if0.pkt_err, if0.pkt_active}; c = 32'(if0.err_cnt); end
      1: begin f = {if1.err_valid, if1.err, if1.pkt_done, if1.pkt_err, if1.pkt_active}; c = 32'(if1.err_cnt); end
      default: begin f = {if2.err_valid, if2.err, if2.pkt_done, if2.pkt_err, if2.pkt_active}; c = 32'(if2.err_cnt); end
    endcase
  endtask

  task automatic check_all();
    logic [4:0]  f;
    logic [31:0] c;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, f, c);
      check("err_valid",  i, 32'(f[4]), 32'(e_ev[i]));
      check("err",        i, 32'(f[3]), 32'(e_err[i]));
      check("pkt_done",   i, 32'(f[2]), 32'(e_pd[i]));
      check("pkt_err",    i, 32'(f[1]), 32'(e_pe[i]));
      check("pkt_active", i, 32'(f[0]), 32'(e_act[i]));
      check("err_cnt",    i, c, 32'(e_cnt[i]));
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic pb, last, clr);
    if0.in_valid = v; if0.in_data = d; if0.in_pb = pb; if0.in_last = last; if0.clr_cnt = clr;
    if1.in_valid = v; if1.in_data = d; if1.in_pb = pb; if1.in_last = last; if1.clr_cnt = clr;
    if2.in_valid = v; if2.in_data = d; if2.in_pb = pb; if2.in_last = last; if2.clr_cnt = clr;
  endtask

  // One clock: apply inputs, let the edge happen, then compare 1 time unit later.
  task automatic step(input logic r, v, input logic [3:0] d, input logic pb, last, clr);
    rst = r;
    drive(v, d, pb, last, clr);
    @(posedge clk);
    model_update(r, v, d, pb, last, clr);
    #1;
    check_all();
  endtask

  initial begin
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2;
    // Reset, with a beat presented during reset that must be discarded.
    step(1, 0, 4'h0, 0, 0, 0);
    step(1, 1, 4'h1, 0, 1, 0);
    step(0, 0, 4'h0, 0, 0, 0);

    // Single-beat packets; even errors 0,0,0,1 and odd errors on the same data.
    step(0, 1, 4'b0000, 0, 1, 0);
    step(0, 1, 4'b0001, 1, 1, 0);
    step(0, 1, 4'b1010, 0, 1, 0);
    step(0, 1, 4'b0001, 0, 1, 0);
    check("even_cnt_after_singles", 0, 32'(if0.err_cnt), 32'd1);
    step(0, 0, 4'h0, 0, 0, 0);

    // Odd-mode pattern from the plan.
    step(0, 1, 4'b0000, 1, 1, 0);
    check("odd_err_0000_pb1", 1, 32'(if1.err), 32'd0);
    step(0, 1, 4'b0000, 0, 1, 0);
    check("odd_err_0000_pb0", 1, 32'(if1.err), 32'd1);
    step(0, 1, 4'b1010, 1, 1, 0);
    check("odd_err_1010_pb1", 1, 32'(if1.err), 32'd0);

    // 3-beat packet with an error in the middle, then a clean 2-beat packet.
    step(0, 1, 4'b0011, 0, 0, 0);
    check("pkt_active_beat1", 0, 32'(if0.pkt_active), 32'd1);
    step(0, 1, 4'b0111, 0, 0, 0);
    step(0, 1, 4'b1111, 0, 1, 0);
    check("pkt_err_3beat", 0, 32'({if0.pkt_done, if0.pkt_err}), 32'b11);
    step(0, 1, 4'b0011, 0, 0, 0);
    step(0, 1, 4'b0110, 0, 1, 0);
    check("pkt_err_clean2", 0, 32'({if0.pkt_done, if0.pkt_err}), 32'b10);

    // Saturation on the 2-bit counter, then clear-with-error and clear alone.
    step(0, 0, 4'h0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 4'b0001, 0, 1, 0);
    check("sat_cnt_held", 2, 32'(if2.err_cnt), 32'd3);
    step(0, 1, 4'b0001, 0, 1, 1);
    check("clr_with_err", 2, 32'(if2.err_cnt), 32'd1);
    step(0, 0, 4'h0, 0, 0, 1);
    check("clr_alone", 2, 32'(if2.err_cnt), 32'd0);

    // Reset mid-packet: the stale error must not reach the next packet.
    step(0, 1, 4'b0001, 0, 0, 0);
    step(0, 1, 4'b0011, 0, 0, 0);
    step(1, 0, 4'h0, 0, 0, 0);
    check("rst_mid_active", 0, 32'(if0.pkt_active), 32'd0);
    step(0, 1, 4'b0011, 0, 1, 0);
    check("after_rst_pkt", 0, 32'({if0.pkt_done, if0.pkt_err}), 32'b10);

    // Gapped stream, including in_last on an idle cycle.
    step(0, 1, 4'b0001, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 0);
    check("idle_last_ignored", 0, 32'({if0.err_valid, if0.pkt_done, if0.pkt_active}), 32'b001);
    step(0, 1, 4'b0011, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0);
    step(0, 1, 4'b0000, 0, 1, 0);
    check("gapped_pkt_end", 0, 32'({if0.pkt_done, if0.pkt_err}), 32'b11);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(1'(($urandom % 60) == 0), 1'(($urandom % 3) != 0), 4'($urandom), 1'($urandom),
           1'(($urandom % 4) == 0), 1'(($urandom % 25) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
Parametrised, clocked successor to the team's 4-bit even-parity checker. Checks a stream of DATA_W-bit beats, each carrying its own parity bit, in even or odd mode. Registers a per-beat error result, aggregates errors over a packet delimited by in_last, and keeps a saturating error counter. Sits on the receive side of serial/byte links, after deserialisation and before the consumer.

Parameters:
DATA_W, 8, width of in_data (≥1)
ODD_MODE, 0, 0 = even parity expected (XOR of data+pb = 0); 1 = odd parity expected (XOR = 1)
CNT_W, 8, width of err_cnt (≥1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  beat present this cycle (no backpressure; always accepted)
in_data  input  DATA_W  beat data
in_pb  input  1  parity bit for this beat
in_last  input  1  beat is last of packet (qualified by in_valid)
clr_cnt  input  1  synchronous clear of err_cnt
err_valid  output  1  1-cycle pulse: beat result on err
err  output  1  beat parity error, valid when err_valid=1
pkt_done  output  1  1-cycle pulse: packet ended
pkt_err  output  1  any beat in finished packet had error, valid when pkt_done=1
pkt_active  output  1  1 while inside a multi-beat packet (state IN_PKT)
err_cnt  output  CNT_W  count of erroneous beats, saturating

Behaviour:
- Reset (rst=1 at clock edge): err_valid=0, err=0, pkt_done=0, pkt_err=0, pkt_active=0, err_cnt=0, state=IDLE, packet error accumulator=0. Beats presented during reset are discarded.
- beat_err = (^in_data) ^ in_pb ^ ODD_MODE; evaluated only when in_valid=1.
- Latency: 1 cycle. Beat accepted at edge N -> err_valid=1, err=beat_err visible after edge N, for exactly one cycle. When in_valid=0, err_valid=0 and err=0 next cycle.
- Back-to-back beats are allowed every cycle; each produces its own err_valid pulse.
- Accumulator acc: cleared when a packet ends; acc_next = acc | beat_err on each accepted beat.
- State machine, 2 states:
  - IDLE: in_valid & ~in_last -> IN_PKT with acc = beat_err. in_valid & in_last -> stay IDLE, single-beat packet: pkt_done=1, pkt_err=beat_err next cycle.
  - IN_PKT: in_valid & ~in_last -> stay, acc |= beat_err. in_valid & in_last -> IDLE, pkt_done=1, pkt_err = acc | beat_err next cycle, acc cleared.
  - pkt_active = (state == IN_PKT), registered.
- pkt_done and err_valid for the last beat assert in the same cycle. pkt_err=0 whenever pkt_done=0.
- in_last with in_valid=0 is ignored.
- err_cnt: +1 per accepted beat with beat_err=1, saturating at 2^CNT_W-1 (holds, never wraps).
- clr_cnt=1: err_cnt is cleared. If an erroneous beat arrives in the same cycle, clear first, then increment -> err_cnt=1.
- clr_cnt does not affect the packet state or accumulator.
- Reset mid-packet: packet abandoned. No pkt_done is produced for it. The next beat starts a fresh packet in IDLE.

Test Plan:
- Even mode, DATA_W=4, single-beat packets: (0000,pb0), (0001,pb1), (1010,pb0), (0001,pb0), each with in_last=1 -> err=0,0,0,1 one cycle later; pkt_done on every beat with pkt_err=0,0,0,1; err_cnt ends at 1.
- ODD_MODE=1, DATA_W=4: (0000,pb1) -> err=0; (0000,pb0) -> err=1; (1010,pb1) -> err=0.
- 3-beat packet, even mode: (0011,pb0), (0111,pb0) [error], (1111,pb0,last) -> pkt_active=1 after beat 1 until after beat 3; err pulses 0,1,0; single pkt_done with pkt_err=1; the next clean 2-beat packet gives pkt_err=0.
- Saturation, CNT_W=2: 5 consecutive erroneous beats -> err_cnt 1,2,3,3,3. Then clr_cnt together with an erroneous beat -> err_cnt=1. clr_cnt alone -> 0.
- Reset mid-packet: 2 beats without last (one erroneous), rst for 1 cycle -> all outputs 0, pkt_active=0. A following single-beat clean last packet -> pkt_done=1, pkt_err=0 (the stale error is not carried over).
- Gapped stream: valid beats with idle cycles between them, and in_last=1 while in_valid=0 -> no err_valid or pkt_done on idle cycles; the packet ends only on a valid last beat.
